weighted_sum: RTL and testbench
===============================

# weighted_sum

Combines an 8-bit binary input vector with eight signed fixed-point weights and produces their saturated weighted sum. It is the accumulation front end of a single-layer perceptron neuron; the activation/threshold stage consumes `sum` downstream. A registered three-stage adder tree gives a fixed three-cycle latency and accepts a new input on every clock.

## Interface
Parameters: none. Widths are fixed: 8 inputs, 32-bit weights, Q16.16 format.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `x`  input  8  binary input vector; bit i enables weight i.
- `w`  input  256  eight packed signed Q16.16 weights; weight i = `w[32*i+31 : 32*i]`.
- `sum`  output  32  signed Q16.16 saturated weighted sum, registered.

## Operation
- Term i = weight i if `x[i]`=1, else 0. No multipliers: each term is a mask.
- Result = Σ term i over i=0..7, computed in full precision: 35-bit signed, so no intermediate overflow.
- Adder tree:
  - Stage 1: the eight masked terms sign-extended into four 33-bit pair sums (0+1, 2+3, 4+5, 6+7), registered.
  - Stage 2: two 34-bit sums, registered.
  - Stage 3: one 35-bit sum, saturated to 32 bits and registered into `sum`.
- Saturation, two's complement:
  - Result > 0x7FFFFFFF → `sum` = 0x7FFFFFFF.
  - Result < −2^31 → `sum` = 0x80000000.
  - Otherwise `sum` = the low 32 bits.
- Q16.16 format is unchanged through the block, because terms are only added. Example: 0x00008000 = 0.5, 0x00010000 = 1.0.
- No handshake and no valid signal: the block is a free-running pipeline, and `x`/`w` may change every cycle.

## Timing
- Reset: if `rst`=0 at a rising edge, all pipeline registers and `sum` become 0 at that edge. `sum` reset value = 0x00000000.
- Latency:
  - `x`/`w` sampled at rising edge k appear on `sum` after rising edge k+2 (three edges including k).
  - `sum` is stable until the next edge.
- Throughput: one result per clock.
- First result after reset: with `rst`=1 first sampled at edge r, `sum` reflects edge-r inputs after edge r+2. Before that, `sum` stays 0.
- Reset mid-operation:
  - All in-flight results are discarded; nothing from before the reset ever appears on `sum`.
  - `sum` = 0 from the reset edge until the first post-reset result.
- Simultaneous reset and input change: reset wins, and the inputs at that edge are discarded.
- All-zero `x`: `sum` = 0 regardless of `w`.
- `x` changing every cycle: each sample's result appears exactly three edges later, in order, with no mixing between samples.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `x`=0xFF and every weight 0x00008000 → `sum`=0x00000000 throughout and for 2 edges after release. It reaches 0x00040000 on the third edge.
- Single input, every weight 0x00008000, `x` = 1<<i for i=0..7, each held 10 cycles → `sum`=0x00008000 three edges after each change. Also check that bit i selects only weight i: set weight i = 0x00010000 + i, with other weights 0, for each i.
- All inputs: every weight 0x00008000, `x`=0xFF → 0x00040000. Then `x`=0x0F → 0x00020000, then `x`=0x00 → 0x00000000. Check latency is exactly 3 edges.
- Signed mix: weight 0 = 0xFFFF8000 (−0.5), weight 1 = 0x00010000, other weights 0x00004000.
  - `x`=0x03 → 0x00008000.
  - `x`=0x01 → 0xFFFF8000.
  - `x`=0xFF → 0x00020000.
- Saturation:
  - Every weight 0x7FFFFFFF, `x`=0xFF → 0x7FFFFFFF.
  - Every weight 0x80000000, `x`=0xFF → 0x80000000.
  - Two weights 0x40000000, `x`=0x03 → 0x7FFFFFFF.
- Back-to-back pipelining and mid-stream reset:
  - Change `x` every cycle through 0x01, 0x03, 0x07, 0xFF, every weight 0x00008000 → `sum` sequence 0x8000, 0x10000, 0x18000, 0x40000, one per cycle.
  - Assert `rst`=0 for one edge mid-sequence → `sum` drops to 0 at that edge and resumes 3 edges after release, with no stale values.

Source files
------------

// File: rtl/weighted_sum.sv
// weighted_sum: masked sum of eight Q16.16 weights through a 3-stage registered adder tree, saturated to 32 bits
module weighted_sum (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   x,
    input  logic [255:0] w,
    output logic [31:0]  sum
);
    logic signed [31:0] w_term [8];
    logic signed [32:0] w_s1   [4];
    logic signed [33:0] w_s2   [2];
    logic signed [34:0] w_s3;
    logic        [31:0] w_sat;
    logic signed [32:0] r_s1   [4];
    logic signed [33:0] r_s2   [2];

    // mask each weight by its input bit and form the sign-extended pair sums
    always_comb begin
        for (int i = 0; i < 8; i++) w_term[i] = x[i] ? w[32*i +: 32] : '0;
        for (int j = 0; j < 4; j++) w_s1[j] = 33'(w_term[2*j]) + 33'(w_term[2*j+1]);
        for (int j = 0; j < 2; j++) w_s2[j] = 34'(r_s1[2*j]) + 34'(r_s1[2*j+1]);
        w_s3  = 35'(r_s2[0]) + 35'(r_s2[1]);
        w_sat = (w_s3 > 35'sh0_7FFF_FFFF)  ? 32'h7FFF_FFFF :
                (w_s3 < -35'sh0_8000_0000) ? 32'h8000_0000 : w_s3[31:0];
    end

    // pipeline registers; active-low reset flushes every in-flight sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 4; j++) r_s1[j] <= '0;
            for (int j = 0; j < 2; j++) r_s2[j] <= '0;
            sum <= '0;
        end else begin
            for (int j = 0; j < 4; j++) r_s1[j] <= w_s1[j];
            for (int j = 0; j < 2; j++) r_s2[j] <= w_s2[j];
            sum <= w_sat;
        end
    end
endmodule

// File: tb/tb_weighted_sum.sv
// tb_weighted_sum: scoreboard bench for weighted_sum with directed and random stimulus
module tb_weighted_sum;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   x   = '0;
    logic [255:0] w   = '0;
    logic [31:0]  sum;

    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int popped = 0;

    logic [31:0] exp_q [$];
    logic [31:0] inflight [$];
    logic [7:0]  xlog [$];

    weighted_sum dut (.clk(clk), .rst(rst), .x(x), .w(w), .sum(sum));

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [7:0] xv, input logic [255:0] wv);
        longint s = 0;
        for (int i = 0; i < 8; i++)
            if (xv[i]) s += longint'($signed(wv[32*i +: 32]));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [255:0] all_w(input logic [31:0] v);
        return {8{v}};
    endfunction

    // apply one sample and predict what sum shows right after this edge
    task automatic step(input logic [7:0] xv, input logic [255:0] wv, input logic rv);
        logic [31:0] out;
        @(negedge clk);
        x = xv; w = wv; rst = rv;
        @(posedge clk);
        out = 32'h0;
        if (!rv) inflight.delete();
        else begin
            inflight.push_back(model(xv, wv));
            if (inflight.size() == 3) out = inflight.pop_front();
        end
        exp_q.push_back(out);
        xlog.push_back(xv);
        pushed++;
    endtask

    task automatic hold(input logic [7:0] xv, input logic [255:0] wv, input int n);
        for (int k = 0; k < n; k++) step(xv, wv, 1'b1);
    endtask

    // monitor: compare sum against the scoreboard every cycle
    initial begin
        logic [31:0] e;
        logic [7:0]  xs;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                xs = xlog.pop_front();
                popped++;
                total++;
                if (sum !== e) begin
                    bad++;
                    $display("FAIL sum @%0t (x at this edge=%h): got %h want %h", $time, xs, sum, e);
                end
            end
        end
    end

    initial begin
        logic [255:0] wv;
        logic [31:0]  half = 32'h0000_8000;
        for (int k = 0; k < 5; k++) step(8'hFF, all_w(half), 1'b0);
        hold(8'hFF, all_w(half), 3);
        for (int i = 0; i < 8; i++) hold(8'(1 << i), all_w(half), 10);
        for (int i = 0; i < 8; i++) begin
            wv = '0;
            wv[32*i +: 32] = 32'h0001_0000 + 32'(i);
            hold(8'(1 << i), wv, 4);
            hold(~8'(1 << i), wv, 4);
            hold(8'hFF, wv, 4);
        end
        hold(8'hFF, all_w(half), 4);
        hold(8'h0F, all_w(half), 4);
        hold(8'h00, all_w(half), 4);
        wv = {{6{32'h0000_4000}}, 32'h0001_0000, 32'hFFFF_8000};
        hold(8'h03, wv, 4);
        hold(8'h01, wv, 4);
        hold(8'hFF, wv, 4);
        hold(8'hFF, all_w(32'h7FFF_FFFF), 4);
        hold(8'hFF, all_w(32'h8000_0000), 4);
        hold(8'h03, {{6{32'h0}}, {2{32'h4000_0000}}}, 4);
        hold(8'h00, all_w(32'h7FFF_FFFF), 4);
        hold(8'h01, all_w(half), 1);
        hold(8'h03, all_w(half), 1);
        hold(8'h07, all_w(half), 1);
        hold(8'hFF, all_w(half), 1);
        hold(8'h00, all_w(half), 3);
        hold(8'h01, all_w(half), 1);
        hold(8'h03, all_w(half), 1);
        step(8'h07, all_w(half), 1'b0);
        hold(8'hFF, all_w(half), 1);
        hold(8'h01, all_w(half), 1);
        hold(8'h03, all_w(half), 1);
        hold(8'h07, all_w(half), 4);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 8; i++)
                wv[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 32'h3FFFF)) - 32'sh2_0000);
            step(8'($urandom()), wv, $urandom_range(0, 19) != 0);
        end
        hold(8'h00, '0, 3);
        @(negedge clk);
        total++;
        if (popped != pushed) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d checked want %0d", popped, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
